// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx
//
// Hamming(7,4) encoder with a serial transmitter. A nibble is accepted over a
// valid/ready handshake and encoded into a 7-bit codeword. One codeword bit can
// optionally be flipped to inject a fault. The frame is then shifted out LSB first
// between a start bit (0) and a stop bit (1). Each bit is held for BIT_CYCLES clocks.
//
// Codeword layout (bit i = position i+1):
//   pos 1 = p1, 2 = p2, 3 = d0, 4 = p4, 5 = d1, 6 = d2, 7 = d3
//
// Ports
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   in_valid_i     upstream offers in_data_i
//   in_data_i      data nibble d[3:0]
//   inject_pos_i   0: no fault; 1..7: flip that codeword position (sampled at accept)
//   in_ready_o     block can accept (IDLE and not in reset)
//   codeword_o     registered transmitted codeword (post-injection)
//   cw_valid_o     one-cycle pulse in the cycle after accept
//   tx_serial_o    serial line, idles high
//   tx_busy_o      high from the cycle after accept through the last stop-bit cycle
//   frame_done_o   one-cycle pulse in the last cycle of the stop bit

module hamming_encoder_tx #(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  logic [3:0] in_data_i,
    input  logic [2:0] inject_pos_i,
    output logic       in_ready_o,
    output logic [6:0] codeword_o,
    output logic       cw_valid_o,
    output logic       tx_serial_o,
    output logic       tx_busy_o,
    output logic       frame_done_o
);

    // The bit-cycle counter needs at least one bit even when BIT_CYCLES is 1.
    localparam int unsigned CntW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BIT_CYCLES - 1);
    localparam logic [2:0] LastIdx = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Encoding helpers
    // ------------------------------------------------------------------
    function automatic logic [6:0] encode_nibble(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [6:0] inject_mask(input logic [2:0] pos);
        logic [6:0] mask;
        mask = '0;
        if (pos != 3'd0) begin
            mask = 7'd1 << (pos - 3'd1);
        end
        return mask;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      codeword_q, codeword_d;
    logic            cw_valid_q, cw_valid_d;
    logic            tx_serial_q, tx_serial_d;
    logic            tx_busy_q, tx_busy_d;
    logic            frame_done_q, frame_done_d;

    logic accept;
    logic bit_end;

    assign in_ready_o = (state_q == StIdle) && !rst_i;
    assign accept     = in_valid_i && in_ready_o;
    assign bit_end    = (cnt_q == CntLast);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        codeword_d = codeword_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StStart;
                    cnt_d      = '0;
                    idx_d      = '0;
                    codeword_d = encode_nibble(in_data_i) ^ inject_mask(inject_pos_i);
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Outputs are registered: derive them from the state being entered so they
    // line up with that state's cycles.
    always_comb begin
        tx_serial_d = 1'b1;
        unique case (state_d)
            StIdle:  tx_serial_d = 1'b1;
            StStart: tx_serial_d = 1'b0;
            StData:  tx_serial_d = codeword_d[idx_d];
            StStop:  tx_serial_d = 1'b1;
            default: tx_serial_d = 1'b1;
        endcase

        cw_valid_d   = accept;
        tx_busy_d    = (state_d != StIdle);
        // Last cycle of the stop bit; with BIT_CYCLES == 1 this is the entry cycle.
        frame_done_d = (state_d == StStop) && (cnt_d == CntLast);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            codeword_q   <= '0;
            cw_valid_q   <= 1'b0;
            tx_serial_q  <= 1'b1;
            tx_busy_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            codeword_q   <= codeword_d;
            cw_valid_q   <= cw_valid_d;
            tx_serial_q  <= tx_serial_d;
            tx_busy_q    <= tx_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign codeword_o   = codeword_q;
    assign cw_valid_o   = cw_valid_q;
    assign tx_serial_o  = tx_serial_q;
    assign tx_busy_o    = tx_busy_q;
    assign frame_done_o = frame_done_q;

    // ------------------------------------------------------------------
    // Sanity checks
    // ------------------------------------------------------------------
    if (BIT_CYCLES < 1) begin : g_bad_param
        $error("BIT_CYCLES must be at least 1");
    end

    // The data index never leaves the 7-bit codeword.
    assert property (@(posedge clk_i) disable iff (rst_i) idx_q <= LastIdx);
    // frame_done only ever appears while the line carries the stop bit.
    assert property (@(posedge clk_i) disable iff (rst_i) frame_done_q |-> tx_serial_q);

endmodule

// File: tb/tb_hamming_encoder_tx.sv
module tb_hamming_encoder_tx;

    logic       clk;
    logic       rst;
    logic       sel;          // 0: BIT_CYCLES=4 instance, 1: BIT_CYCLES=1 instance
    logic       in_valid;
    logic [3:0] in_data;
    logic [2:0] inject_pos;

    logic       rdy4, cwv4, ser4, busy4, done4;
    logic [6:0] cw4;
    logic       rdy1, cwv1, ser1, busy1, done1;
    logic [6:0] cw1;

    logic       o_ready, o_cwv, o_ser, o_busy, o_done;
    logic [6:0] o_cw;

    int checks = 0;
    int errors = 0;

    hamming_encoder_tx #(.BIT_CYCLES(4)) u_dut4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid & ~sel),
        .in_data_i    (in_data),
        .inject_pos_i (inject_pos),
        .in_ready_o   (rdy4),
        .codeword_o   (cw4),
        .cw_valid_o   (cwv4),
        .tx_serial_o  (ser4),
        .tx_busy_o    (busy4),
        .frame_done_o (done4)
    );

    hamming_encoder_tx #(.BIT_CYCLES(1)) u_dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid & sel),
        .in_data_i    (in_data),
        .inject_pos_i (inject_pos),
        .in_ready_o   (rdy1),
        .codeword_o   (cw1),
        .cw_valid_o   (cwv1),
        .tx_serial_o  (ser1),
        .tx_busy_o    (busy1),
        .frame_done_o (done1)
    );

    assign o_ready = sel ? rdy1  : rdy4;
    assign o_cwv   = sel ? cwv1  : cwv4;
    assign o_ser   = sel ? ser1  : ser4;
    assign o_busy  = sel ? busy1 : busy4;
    assign o_done  = sel ? done1 : done4;
    assign o_cw    = sel ? cw1   : cw4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference encoder: place data bits on the non-power-of-two positions, then each
    // parity bit 2^k is the XOR of every data position whose index has bit k set.
    function automatic logic [6:0] model_cw(input logic [3:0] d, input logic [2:0] pos);
        logic [7:0] p;
        int di;
        p  = '0;
        di = 0;
        for (int q = 1; q <= 7; q++) begin
            if ((q & (q - 1)) != 0) begin
                p[q] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            for (int q = 1; q <= 7; q++) begin
                if (((q >> k) & 1) == 1 && q != (1 << k)) p[1 << k] = p[1 << k] ^ p[q];
            end
        end
        if (pos != 3'd0) p[pos] = ~p[pos];
        return p[7:1];
    endfunction

    function automatic logic frame_bit(input logic [6:0] cw, input int k);
        if (k == 0) return 1'b0;
        if (k == 8) return 1'b1;
        return cw[k-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offers a nibble, waits for accept, then checks every cycle of the frame and the
    // idle cycle after it. With chain set, in_valid stays high carrying the next nibble.
    // Entered and left at a falling edge.
    task automatic run_frame(input logic [3:0] d, input logic [2:0] p, input logic [6:0] exp_cw,
                             input bit chain, input logic [3:0] nd, input logic [2:0] np);
        int w;
        int bc;
        int k;
        bc         = sel ? 1 : 4;
        in_valid   = 1'b1;
        in_data    = d;
        inject_pos = p;
        w = 0;
        while (!o_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("accept_wait d=%h", d), 32'(w < 200), 32'd1);
        if (w >= 200) begin
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (chain) begin
            in_data    = nd;
            inject_pos = np;
        end else begin
            in_valid   = 1'b0;
            in_data    = 4'($urandom);
            inject_pos = 3'($urandom);
        end
        for (int c = 1; c <= 9 * bc; c++) begin
            k = (c - 1) / bc;
            check($sformatf("serial d=%h c=%0d", d, c), 32'(o_ser), 32'(frame_bit(exp_cw, k)));
            check($sformatf("busy c=%0d", c), 32'(o_busy), 32'd1);
            check($sformatf("ready c=%0d", c), 32'(o_ready), 32'd0);
            check($sformatf("cw_valid c=%0d", c), 32'(o_cwv), 32'(c == 1));
            check($sformatf("frame_done c=%0d", c), 32'(o_done), 32'(c == 9 * bc));
            check($sformatf("codeword d=%h p=%0d", d, p), 32'(o_cw), 32'(exp_cw));
            @(negedge clk);
        end
        check("idle_ready", 32'(o_ready), 32'd1);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_serial", 32'(o_ser), 32'd1);
        check("idle_done", 32'(o_done), 32'd0);
        check("idle_codeword", 32'(o_cw), 32'(exp_cw));
    endtask

    typedef struct {
        logic [3:0] data;
        logic [2:0] pos;
        logic [6:0] exp_cw;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [3:0] rd;
        logic [2:0] rp;
        logic [3:0] nd;
        logic [2:0] np;

        vecs[0]  = '{4'b0000, 3'd0, 7'b0000000};
        vecs[1]  = '{4'b1111, 3'd0, 7'b1111111};
        vecs[2]  = '{4'b0001, 3'd0, 7'b0000111};
        vecs[3]  = '{4'b1011, 3'd0, 7'b1010101};
        vecs[4]  = '{4'b1011, 3'd1, 7'b1010100};
        vecs[5]  = '{4'b1011, 3'd2, 7'b1010111};
        vecs[6]  = '{4'b1011, 3'd3, 7'b1010001};
        vecs[7]  = '{4'b1011, 3'd4, 7'b1011101};
        vecs[8]  = '{4'b1011, 3'd5, 7'b1000101};
        vecs[9]  = '{4'b1011, 3'd6, 7'b1110101};
        vecs[10] = '{4'b1011, 3'd7, 7'b0010101};

        // Reset with in_valid high: reset wins, no accept.
        sel        = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        in_data    = 4'b1011;
        inject_pos = 3'd0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check($sformatf("rst_ready s=%0d", s), 32'(o_ready), 32'd0);
            check($sformatf("rst_serial s=%0d", s), 32'(o_ser), 32'd1);
            check($sformatf("rst_codeword s=%0d", s), 32'(o_cw), 32'd0);
            check($sformatf("rst_cw_valid s=%0d", s), 32'(o_cwv), 32'd0);
            check($sformatf("rst_busy s=%0d", s), 32'(o_busy), 32'd0);
            check($sformatf("rst_done s=%0d", s), 32'(o_done), 32'd0);
        end
        sel      = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(o_busy), 32'd0);
        check("post_rst_ready", 32'(o_ready), 32'd1);

        // Table-driven encode and injection vectors, BIT_CYCLES=4.
        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].data, vecs[i].pos, vecs[i].exp_cw, 1'b0, 4'd0, 3'd0);
        end

        // Back-to-back: in_valid held across two frames; second nibble offered during the
        // first frame must not disturb it.
        run_frame(4'b0110, 3'd0, model_cw(4'b0110, 3'd0), 1'b1, 4'b1001, 3'd3);
        run_frame(4'b1001, 3'd3, model_cw(4'b1001, 3'd3), 1'b0, 4'd0, 3'd0);

        // Reset during DATA bit 3 (frame bit 4 = cycles 17..20 after accept).
        in_valid   = 1'b1;
        in_data    = 4'b1011;
        inject_pos = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("mid_serial_d3", 32'(o_ser), 32'(frame_bit(7'b1010101, 4)));
        check("mid_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_serial", 32'(o_ser), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_codeword", 32'(o_cw), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_cw_valid", 32'(o_cwv), 32'd0);
        check("abort_ready", 32'(o_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check($sformatf("abort_no_done c=%0d", c), 32'(o_done), 32'd0);
            check($sformatf("abort_idle_ser c=%0d", c), 32'(o_ser), 32'd1);
        end
        run_frame(4'b1011, 3'd0, 7'b1010101, 1'b0, 4'd0, 3'd0);

        // Randomized frames against the reference model, some chained back-to-back.
        rd = 4'($urandom);
        rp = 3'($urandom);
        for (int i = 0; i < 24; i++) begin
            nd = 4'($urandom);
            np = 3'($urandom);
            run_frame(rd, rp, model_cw(rd, rp), ($urandom_range(0, 2) == 0), nd, np);
            rd = nd;
            rp = np;
        end
        in_valid = 1'b0;
        @(negedge clk);

        // BIT_CYCLES=1 instance: 9-cycle frames, frame_done on the stop bit.
        sel = 1'b1;
        #1;
        run_frame(4'b1011, 3'd0, 7'b1010101, 1'b1, 4'b0001, 3'd5);
        run_frame(4'b0001, 3'd5, model_cw(4'b0001, 3'd5), 1'b0, 4'd0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            rd = 4'($urandom);
            rp = 3'($urandom);
            run_frame(rd, rp, model_cw(rd, rp), 1'b0, 4'd0, 3'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
